// File: rtl/dmem_pkg.sv
// Shared constants and arbiter state encodings for the data-memory arbiter.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 11;
   localparam int DMEM_DATA_W = 32;

   // Arbiter ownership states: IDLE arbitrates, OWNk restricts grants to port k
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_e;

   // Picks the port preferred on contention for a given pointer and mode
   function automatic logic preferred_port(input logic ptr, input logic rr_mode);
      return rr_mode ? ptr : 1'b0;
   endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-input picker: round-robin (mode=1, ptr selects preferred port) or
// fixed priority (mode=0, port 0 always wins). Output is one-hot or zero.
module dmem_rr_pick
   import dmem_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   input  logic       mode_i,
   output logic [1:0] gnt_o
);

   logic pref;

   assign pref = preferred_port(ptr_i, mode_i);

   // Single requester wins outright; on contention the preferred port wins
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = pref ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port RAM2Kx32 data memory.
// Port 0 is the execute-stage load/store port, port 1 the loader/debug port.
// Handshake: pN_gnt is combinational and means the beat presented on pN_*
// this cycle is accepted by the RAM at the next rising edge; a requester
// keeps pN_req and its fields stable until it sees pN_gnt. Reads return
// pN_rvalid/pN_rdata exactly one cycle after the granting cycle, with no
// back-pressure on the return path. pN_lock on a granted beat keeps the
// memory owned by port N until a beat (or idle cycle) with pN_lock low.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = DMEM_ADDR_W,
   parameter int DATA_W  = DMEM_DATA_W,
   parameter bit RR_MODE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   // port 0: execute-stage load/store
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic              p0_lock,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   // port 1: program loader / debug
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic              p1_lock,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   // RAM2Kx32 pins, active-low controls
   output logic              mem_cen,
   output logic              mem_wen,
   output logic              mem_oen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_d,
   input  logic [DATA_W-1:0] mem_q,
   // ownership state for observation
   output logic [1:0]        dbg_state_o
);

   arb_state_e        state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_port_q, rd_port_d;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_d_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   logic [1:0]        req;
   logic [1:0]        pick;
   logic [1:0]        gnt;

   assign req = {p1_req, p0_req};

   dmem_rr_pick u_pick (
      .req_i  (req),
      .ptr_i  (rr_ptr_q),
      .mode_i (RR_MODE),
      .gnt_o  (pick)
   );

   // Grant decision and ownership next-state; reset suppresses every grant
   always_comb begin
      gnt      = 2'b00;
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ARB_IDLE: begin
            gnt = pick;
            if (pick[0]) begin
               rr_ptr_d = 1'b1;
               if (p0_lock) state_d = ARB_OWN0;
            end else if (pick[1]) begin
               rr_ptr_d = 1'b0;
               if (p1_lock) state_d = ARB_OWN1;
            end
         end
         ARB_OWN0: begin
            // only the owner may be granted; dropping lock ends ownership
            gnt = {1'b0, p0_req};
            if (!p0_lock) state_d = ARB_IDLE;
         end
         ARB_OWN1: begin
            gnt = {p1_req, 1'b0};
            if (!p1_lock) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
      if (rst) gnt = 2'b00;
   end

   assign p0_gnt = gnt[0];
   assign p1_gnt = gnt[1];

   // RAM pins follow the granted port; without a grant addr/data hold so that
   // an idle requester's (possibly undefined) fields never reach the pins
   always_comb begin
      mem_cen  = 1'b1;
      mem_wen  = 1'b1;
      mem_addr = mem_addr_q;
      mem_d    = mem_d_q;
      if (gnt[0]) begin
         mem_cen  = 1'b0;
         mem_wen  = ~p0_we;
         mem_addr = p0_addr;
         mem_d    = p0_wdata;
      end else if (gnt[1]) begin
         mem_cen  = 1'b0;
         mem_wen  = ~p1_we;
         mem_addr = p1_addr;
         mem_d    = p1_wdata;
      end
   end

   assign mem_oen = 1'b0;

   // A read beat leaves a one-cycle pending marker tagged with its port
   always_comb begin
      rd_pend_d = (gnt[0] & ~p0_we) | (gnt[1] & ~p1_we);
      rd_port_d = gnt[1];
   end

   // Return path: RAM output passes straight through in the cycle after the
   // read grant; the other port keeps showing its last returned word
   always_comb begin
      p0_rvalid = rd_pend_q & ~rd_port_q & ~rst;
      p1_rvalid = rd_pend_q &  rd_port_q & ~rst;
      p0_rdata  = p0_rvalid ? mem_q : rdata0_q;
      p1_rdata  = p1_rvalid ? mem_q : rdata1_q;
   end

   assign dbg_state_o = state_q;

   // All arbiter state; reset drops ownership and any pending read
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_port_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_d_q    <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         rd_pend_q  <= rd_pend_d;
         rd_port_q  <= rd_port_d;
         mem_addr_q <= mem_addr;
         mem_d_q    <= mem_d;
         rdata0_q   <= p0_rdata;
         rdata1_q   <= p1_rdata;
      end
   end

endmodule
